// File: rtl/accum_logger.sv
// Accumulator change logger: captures accum values that differ from the last
// captured one into an 8-deep FIFO, tagging each entry with a 4-bit sequence.
module accum_logger (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] accum,
    input  logic       log_en,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [3:0] count,
    output logic       overflow,
    output logic [3:0] drop_cnt
);

    localparam logic [3:0] DEPTH = 4'd8;

    logic [7:0] mem [8];
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] seq, last_val;
    logic       primed;
    logic       capture, pop, full, push, drop;

    always_comb begin
        full    = (count == DEPTH);
        capture = log_en && (!primed || (accum != last_val));
        pop     = out_valid && out_ready;
        // A pop frees the slot in the same edge, so a full FIFO still accepts.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    assign out_valid = (count != 4'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {seq, accum};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            count    <= 4'd0;
            seq      <= 4'd0;
            last_val <= 4'd0;
            primed   <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= 4'd0;
        end else begin
            // log_en high with primed low always captures, so primed just tracks log_en.
            primed <= log_en;
            if (capture) begin
                last_val <= accum;
                seq      <= seq + 4'd1;
            end
            if (push) wr_ptr <= wr_ptr + 3'd1;
            if (pop)  rd_ptr <= rd_ptr + 3'd1;
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 4'hF) drop_cnt <= drop_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_accum_logger.sv
// Directed bench for accum_logger with hand-computed expectations.
module tb_accum_logger;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] accum;
    logic       log_en;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] count;
    logic       overflow;
    logic [3:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    accum_logger dut (
        .clk       (clk),
        .reset     (reset),
        .accum     (accum),
        .log_en    (log_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; accum = 4'd0; log_en = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_count", {4'd0, count}, 8'd0);
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_ovf", {7'd0, overflow}, 8'd0);
        chk("rst_drop", {4'd0, drop_cnt}, 8'd0);

        // Repeated value is captured only once
        reset = 1'b1; log_en = 1'b1; accum = 4'd3;
        step();
        chk("first_cap_data", out_data, 8'h03);
        chk("first_cap_cnt", {4'd0, count}, 8'd1);
        step(); step();
        accum = 4'd5;
        step();
        chk("dedup_count", {4'd0, count}, 8'd2);
        chk("dedup_head", out_data, 8'h03);
        out_ready = 1'b1;
        step();
        chk("dedup_second", out_data, 8'h15);
        step();
        chk("drain_empty_cnt", {4'd0, count}, 8'd0);
        chk("drain_empty_data", out_data, 8'h00);
        out_ready = 1'b0;

        // Overflow: 10 distinct changes into 8 slots
        reset = 1'b0; #2; reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            accum = k[3:0];
            step();
        end
        chk("ovf_count", {4'd0, count}, 8'd8);
        chk("ovf_flag", {7'd0, overflow}, 8'd1);
        chk("ovf_drop", {4'd0, drop_cnt}, 8'd2);
        chk("ovf_head", out_data, 8'h01);

        // Full with simultaneous pop and capture
        out_ready = 1'b1; accum = 4'd11;
        step();
        chk("full_pp_count", {4'd0, count}, 8'd8);
        chk("full_pp_drop", {4'd0, drop_cnt}, 8'd2);
        log_en = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            chk("drain_order", out_data, {i[3:0], 4'(i + 1)});
            step();
        end
        chk("full_pp_last", out_data, 8'hAB);
        step();
        chk("drain2_empty", {4'd0, count}, 8'd0);
        out_ready = 1'b0;

        // Re-enable recaptures an unchanged value
        log_en = 1'b1; accum = 4'd9;
        step(); step();
        chk("reen_once", {4'd0, count}, 8'd1);
        log_en = 1'b0;
        step();
        log_en = 1'b1;
        step();
        chk("reen_count", {4'd0, count}, 8'd2);
        chk("reen_head", out_data, 8'hB9);
        log_en = 1'b0; out_ready = 1'b1;
        step();
        chk("reen_second", out_data, 8'hC9);
        step();
        chk("reen_empty", {7'd0, out_valid}, 8'd0);

        // Streaming with sequence wrap; seq starts at 13
        log_en = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            accum = k[3:0];
            step();
            chk("wrap_data", out_data, {4'(13 + k), k[3:0]});
            chk("wrap_count", {4'd0, count}, 8'd1);
        end
        log_en = 1'b0;
        step();
        chk("wrap_empty", {4'd0, count}, 8'd0);

        // Drop counter saturation
        out_ready = 1'b0; log_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            accum = (k % 2 == 0) ? 4'd1 : 4'd2;
            step();
        end
        chk("sat_count", {4'd0, count}, 8'd8);
        chk("sat_drop", {4'd0, drop_cnt}, 8'h0F);
        chk("sat_ovf", {7'd0, overflow}, 8'd1);

        // Mid-cycle async reset with four entries pending
        log_en = 1'b0; out_ready = 1'b1;
        step(); step(); step(); step();
        out_ready = 1'b0;
        chk("pre_rst_count", {4'd0, count}, 8'd4);
        #2 reset = 1'b0;
        #1;
        chk("async_count", {4'd0, count}, 8'd0);
        chk("async_valid", {7'd0, out_valid}, 8'd0);
        chk("async_data", out_data, 8'h00);
        chk("async_ovf", {7'd0, overflow}, 8'd0);
        chk("async_drop", {4'd0, drop_cnt}, 8'd0);
        #1 reset = 1'b1;
        log_en = 1'b1; accum = 4'd7;
        step();
        chk("post_rst_seq0", out_data, 8'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_logger.md
ACCUM_LOGGER -- requirements
Module: accum_logger

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset; low forces reset state immediately, regardless of clk.
REQ-003 SHALL: accum  input  4  microprocessor accumulator value, sampled every rising edge.
REQ-004 SHALL: log_en  input  1  capture enable; high permits capture of accum changes.
REQ-005 SHALL: out_ready  input  1  consumer accepts the head entry this cycle.
REQ-006 SHALL: out_valid  output  1  FIFO non-empty; out_data holds a valid entry.
REQ-007 SHALL: out_data  output  8  head entry = {seq[3:0], value[3:0]}; 8'h00 when empty.
REQ-008 SHALL: count  output  4  current FIFO occupancy, range 0..8.
REQ-009 SHALL: overflow  output  1  sticky flag: at least one capture was dropped because the FIFO was full.
REQ-010 SHALL: drop_cnt  output  4  count of dropped captures, saturating at 4'hF.

Function
REQ-011 SHALL: Storage is an 8-entry FIFO, 8 bits per entry, with 3-bit read/write pointers that wrap 7->0.
REQ-012 SHALL: A "capture event" occurs at a rising edge when log_en=1 and either primed=0 or accum != last_val.
REQ-013 SHALL: On a capture event, last_val<=accum, primed<=1, and entry {seq, accum} is pushed; seq then increments modulo 16, wrapping 15->0.
REQ-014 SHALL: At a rising edge with log_en=0, primed<=0 and there is no capture; FIFO draining continues unaffected.
REQ-015 SHALL: The first sample after log_en rises is always captured, even if equal to last_val.
REQ-016 SHALL: Push latency: for a capture event at edge N, the entry is visible at out_data/out_valid after edge N, i.e. in the cycle following N.
REQ-017 SHALL: A pop occurs at a rising edge when out_valid=1 and out_ready=1; out_ready while empty has no effect.
REQ-018 SHALL: out_valid, out_data and count are derived from registered state only; no combinational path exists from accum, log_en or out_ready.
REQ-019 SHALL: Capture event while full without a simultaneous pop -> entry dropped, overflow<=1, drop_cnt increments (saturating), seq still increments so the consumer sees the gap.
REQ-020 SHALL: Capture event while full with a simultaneous pop -> both pop and push succeed; count stays 8; no drop.
REQ-021 SHALL: Push and pop in the same cycle at any occupancy 1..7 -> count unchanged and order preserved.
REQ-022 SHALL: Push while empty with out_ready=1 -> no pop that cycle (out_valid was 0); count becomes 1.
REQ-023 SHALL: count = writes minus reads and never exceeds 8 or goes below 0.
REQ-024 SHALL: overflow clears only on reset; drop_cnt holds at 4'hF once saturated.

Reset
REQ-025 SHALL: While reset=0, the following hold: pointers=0, count=0, out_valid=0, out_data=8'h00, overflow=0, drop_cnt=0, seq=0, last_val=0, primed=0.
REQ-026 SHALL: Reset asserted mid-operation discards all FIFO contents immediately, asynchronously; entries pending pop are lost.
REQ-027 SHALL: After reset deasserts, the first rising edge with log_en=1 captures accum as seq 0.

Verification
REQ-028 SHALL: reset low then high; log_en=1; accum 3,3,3,5 on four edges -> entries {0,3},{1,5} only; count=2.
REQ-029 SHALL: out_ready=0; apply 10 distinct accum changes -> count=8, overflow=1, drop_cnt=2; draining yields seq 0..7 in order.
REQ-030 SHALL: FIFO full with out_ready=1 and a capture in the same cycle -> count stays 8, drop_cnt unchanged, new entry appears last.
REQ-031 SHALL: log_en 1->0->1 with accum held at 9 -> 9 captured again on re-enable with the next seq.
REQ-032 SHALL: 17 changes with continuous out_ready=1 -> seq wraps 15->0; out_data 8'h0X follows 8'hFX.
REQ-033 SHALL: Reset pulsed low between clock edges with count=4 -> out_valid=0 and count=0 before the next edge.
